// File: rtl/bit_deserial.sv
// LSB-first serial-to-parallel receiver with framing, a one-word holding
// register on a valid/ready output, and sticky overrun / frame-error flags.
module bit_deserial #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_bit,
    input  logic             i_bit_valid,
    input  logic             i_frame,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_overrun,
    output logic             o_frame_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             complete_s;
    logic [WIDTH-1:0] word_s;

    // Next-state logic: framing FSM, shift register, holding register and flags.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;
        ferr_d     = ferr_q;
        complete_s = 1'b0;
        word_s     = {i_bit, sr_q[WIDTH-2:0]};

        // Clear first so that a set event on the same edge takes priority.
        if (i_clr) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end else begin
            ovr_d  = ovr_q;
            ferr_d = ferr_q;
        end

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (i_bit_valid && i_frame) begin
                    sr_d[0] = i_bit;
                    cnt_d   = CW'(1);
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (i_bit_valid && i_frame) begin
                    ferr_d  = 1'b1;
                    sr_d[0] = i_bit;
                    cnt_d   = CW'(1);
                end else if (i_bit_valid) begin
                    sr_d[cnt_q] = i_bit;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        complete_s = 1'b1;
                        cnt_d      = CW'(0);
                        state_d    = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = S_SHIFT;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CW'(0);
            end
        endcase

        // A word being consumed on this edge frees the slot for the new one.
        if (complete_s) begin
            if (!valid_q || i_ready) begin
                data_d  = word_s;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else begin
            data_d = data_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CW'(0);
            sr_q    <= {WIDTH{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_busy      = (state_q == S_SHIFT);
    assign o_overrun   = ovr_q;
    assign o_frame_err = ferr_q;

endmodule
